stream_burst_source: RTL and testbench
======================================

STREAM_BURST_SOURCE -- requirements
Module: stream_burst_source

Interface
REQ-001 SHALL have parameter WIDTH, default 8: stream data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16384: depth of the downstream StreamingFIFO.
REQ-003 SHALL have parameter COUNT_W, default 14: width of the FIFO occupancy input.
REQ-004 SHALL have parameter LEN_W, default 14: width of the burst length field.
REQ-005 SHALL have port ap_clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port cmd_valid, input, 1 bit: burst command offered.
REQ-008 SHALL have port cmd_ready, output, 1 bit: command accepted when both high.
REQ-009 SHALL have port cmd_len, input, LEN_W bits: burst length in words.
REQ-010 SHALL have port cmd_seed, input, WIDTH bits: first data word of the burst.
REQ-011 SHALL have port fifo_count, input, COUNT_W bits: downstream FIFO occupancy.
REQ-012 SHALL have port out_V_V_TDATA, output, WIDTH bits: stream data to the FIFO.
REQ-013 SHALL have port out_V_V_TVALID, output, 1 bit: stream valid.
REQ-014 SHALL have port out_V_V_TREADY, input, 1 bit: stream ready from the FIFO.
REQ-015 SHALL have port done, output, 1 bit: one-cycle burst-complete pulse.
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse, command rejected.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, CHECK, WAIT_SPACE, SEND and FINISH.
REQ-019 SHALL assert cmd_ready only in IDLE and latch cmd_len and cmd_seed on the handshake, then go to CHECK.
REQ-020 SHALL in CHECK go to FINISH with done=1 if len==0; go to FINISH with err=1 if len>DEPTH-1; otherwise go to WAIT_SPACE.
REQ-021 SHALL compute free = DEPTH-1-fifo_count at COUNT_W+1 bits, unsigned, clamped to 0.
REQ-022 SHALL in WAIT_SPACE remain until free>=len, then enter SEND on the next cycle.
REQ-023 SHALL in SEND drive TVALID=1 and TDATA=(seed+index) mod 2^WIDTH, where index counts accepted words from 0.
REQ-024 SHALL hold TDATA and TVALID stable while TVALID=1 and TREADY=0.
REQ-025 SHALL treat a word as transferred only when TVALID and TREADY are both high on a rising edge.
REQ-026 SHALL drop TVALID in the cycle after the transfer of word len-1 and enter FINISH.
REQ-027 SHALL pulse done (or err) for exactly one cycle in FINISH, then return to IDLE.
REQ-028 SHALL allow a new command in the cycle after FINISH; the added CHECK cycle lets fifo_count reflect the prior burst.
REQ-029 SHALL provide throughput of 1 word/cycle in SEND under continuous TREADY.
REQ-030 SHALL never assert done and err in the same cycle.

Reset
REQ-031 SHALL, on ap_rst=1 at a clock edge, enter IDLE and set TVALID=0, TDATA=0, done=0, err=0, busy=0, cmd_ready=0 during reset, and clear the index counter.
REQ-032 SHALL abandon a reset mid-SEND with no done pulse; cmd_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-033 SHALL place the FSM state enum and the free-space helper function in a shared package, stream_pkg.
REQ-034 SHALL be a single module, with no sub-modules.

Verification
REQ-035 SHALL pass test V1: cmd len=4, seed=0xFE, fifo_count=0, TREADY=1 -> TDATA FE,FF,00,01 on 4 consecutive cycles, then one done pulse.
REQ-036 SHALL pass test V2: len=3 with TREADY low for 2 cycles after word 0 -> word 1 held stable, 3 transfers total, done once.
REQ-037 SHALL pass test V3: DEPTH=16, fifo_count=14, len=4 -> stays in WAIT_SPACE with TVALID=0; drop count to 11 -> SEND starts within 2 cycles.
REQ-038 SHALL pass test V4: len=0 -> done pulse, no TVALID; len=16 with DEPTH=16 -> err pulse, no TVALID.
REQ-039 SHALL pass test V5: ap_rst asserted after word 2 of len=8 -> TVALID=0 the next cycle, no done, and a new command is accepted afterwards.
REQ-040 SHALL pass test V6: back-to-back commands len=2 and len=2 -> 4 words, 2 done pulses, and cmd_ready never high outside IDLE.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg
// Shared definitions for the burst source:
//   state_t    - controller states (IDLE, CHECK, WAIT_SPACE, SEND, FINISH)
//   free_space - free-slot calculation for the downstream FIFO, clamped at 0
package stream_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK      = 3'd1,
    WAIT_SPACE = 3'd2,
    SEND       = 3'd3,
    FINISH     = 3'd4
  } state_t;

  // Free slots = depth-1-count. The FIFO reports occupancy that can exceed
  // depth-1 transiently, so the result is clamped to 0 instead of wrapping.
  function automatic logic [31:0] free_space(input logic [31:0] depth,
                                             input logic [31:0] count);
    logic [31:0] limit;
    limit = depth - 32'd1;
    if (count >= limit) begin
      free_space = 32'd0;
    end else begin
      free_space = limit - count;
    end
  endfunction

endpackage

// File: rtl/stream_burst_source_if.sv
// stream_burst_source_if
// Bundles the command handshake, FIFO occupancy, output stream and status
// signals of the burst source.
//   master : the burst source side (drives cmd_ready, stream, status)
//   slave  : the environment side (drives commands, fifo_count, TREADY)
interface stream_burst_source_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 14,
  parameter int LEN_W   = 14
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [LEN_W-1:0]   cmd_len;
  logic [WIDTH-1:0]   cmd_seed;
  logic [COUNT_W-1:0] fifo_count;
  logic [WIDTH-1:0]   out_V_V_TDATA;
  logic               out_V_V_TVALID;
  logic               out_V_V_TREADY;
  logic               done;
  logic               err;
  logic               busy;

  modport master (
    input  cmd_valid, cmd_len, cmd_seed, fifo_count, out_V_V_TREADY,
    output cmd_ready, out_V_V_TDATA, out_V_V_TVALID, done, err, busy
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_seed, fifo_count, out_V_V_TREADY,
    input  cmd_ready, out_V_V_TDATA, out_V_V_TVALID, done, err, busy
  );

endinterface

// File: rtl/stream_burst_source.sv
// stream_burst_source
// Accepts a burst command (length, seed), checks it against the FIFO depth,
// waits until the downstream FIFO has room for the whole burst, then streams
// seed, seed+1, ... (mod 2^WIDTH) at up to one word per cycle.
// Ports:
//   ap_clk, ap_rst            - clock, synchronous active-high reset
//   cmd_valid/cmd_ready       - command handshake; cmd_len, cmd_seed payload
//   fifo_count                - downstream FIFO occupancy
//   out_V_V_TDATA/TVALID/TREADY - output stream
//   done / err                - one-cycle completion / rejection pulses
//   busy                      - high whenever not IDLE
module stream_burst_source
  import stream_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16384,
  parameter int COUNT_W = 14,
  parameter int LEN_W   = 14
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [WIDTH-1:0]   cmd_seed,
  input  logic [COUNT_W-1:0] fifo_count,
  output logic [WIDTH-1:0]   out_V_V_TDATA,
  output logic               out_V_V_TVALID,
  input  logic               out_V_V_TREADY,
  output logic               done,
  output logic               err,
  output logic               busy
);

  localparam int FREE_W = COUNT_W + 1;
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_s;
  logic [LEN_W-1:0]   len_r;
  logic [WIDTH-1:0]   seed_r;
  logic [LEN_W-1:0]   idx_r;
  logic [LEN_W-1:0]   idx_s;
  logic [WIDTH-1:0]   tdata_r;
  logic [WIDTH-1:0]   tdata_s;
  logic               tvalid_r;
  logic               cmd_ready_r;
  logic               done_r;
  logic               done_s;
  logic               err_r;
  logic               err_s;
  logic               busy_r;
  logic               accept_s;
  logic               xfer_s;
  logic [FREE_W-1:0]  free_s;
  logic               space_ok_s;
  logic               too_long_s;

  assign free_s     = FREE_W'(free_space(32'(DEPTH), 32'(fifo_count)));
  assign space_ok_s = (32'(free_s) >= 32'(len_r));
  assign too_long_s = (32'(len_r) > (32'(DEPTH) - 32'd1));
  assign accept_s   = cmd_valid && cmd_ready_r;
  assign xfer_s     = tvalid_r && out_V_V_TREADY;

  // Next-state, word index and completion pulses.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = CHECK;
          idx_s   = LEN_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        // Empty bursts complete immediately; oversize ones could never fit.
        if (len_r == LEN_ZERO) begin
          state_s = FINISH;
          done_s  = 1'b1;
        end else if (too_long_s) begin
          state_s = FINISH;
          err_s   = 1'b1;
        end else begin
          state_s = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (space_ok_s) begin
          state_s = SEND;
        end else begin
          state_s = WAIT_SPACE;
        end
      end
      SEND: begin
        if (xfer_s) begin
          if (idx_r == (len_r - LEN_ONE)) begin
            state_s = FINISH;
            done_s  = 1'b1;
          end else begin
            idx_s = idx_r + LEN_ONE;
          end
        end else begin
          state_s = SEND;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    tdata_s = seed_r + WIDTH'(idx_s);
  end

  // State register, word index and latched command.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r <= IDLE;
      idx_r   <= LEN_ZERO;
      len_r   <= LEN_ZERO;
      seed_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (accept_s) begin
        len_r  <= cmd_len;
        seed_r <= cmd_seed;
      end else begin
        len_r  <= len_r;
        seed_r <= seed_r;
      end
    end
  end

  // Outputs are registered from the next state so they align with state_r.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      tvalid_r    <= 1'b0;
      tdata_r     <= {WIDTH{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      cmd_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      tvalid_r    <= (state_s == SEND);
      done_r      <= done_s;
      err_r       <= err_s;
      // Only advance data on entry to SEND or after an accepted word, so it
      // stays stable while the sink stalls.
      if (state_s == SEND) begin
        tdata_r <= tdata_s;
      end else begin
        tdata_r <= tdata_r;
      end
    end
  end

  assign cmd_ready      = cmd_ready_r;
  assign busy           = busy_r;
  assign out_V_V_TVALID = tvalid_r;
  assign out_V_V_TDATA  = tdata_r;
  assign done           = done_r;
  assign err            = err_r;

endmodule

// File: tb/tb_stream_burst_source.sv
module tb_stream_burst_source;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int COUNT_W = 14;
  localparam int LEN_W   = 14;

  logic clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 clk = ~clk;

  stream_burst_source_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .LEN_W(LEN_W)) bus();

  logic rand_mode = 1'b0;
  logic rnd_ready = 1'b0;
  logic dir_ready = 1'b1;
  assign bus.out_V_V_TREADY = rand_mode ? rnd_ready : dir_ready;

  stream_burst_source #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COUNT_W(COUNT_W), .LEN_W(LEN_W)) dut (
    .ap_clk         (clk),
    .ap_rst         (ap_rst),
    .cmd_valid      (bus.cmd_valid),
    .cmd_ready      (bus.cmd_ready),
    .cmd_len        (bus.cmd_len),
    .cmd_seed       (bus.cmd_seed),
    .fifo_count     (bus.fifo_count),
    .out_V_V_TDATA  (bus.out_V_V_TDATA),
    .out_V_V_TVALID (bus.out_V_V_TVALID),
    .out_V_V_TREADY (bus.out_V_V_TREADY),
    .done           (bus.done),
    .err            (bus.err),
    .busy           (bus.busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int words_seen = 0;
  int done_seen = 0;
  int err_seen = 0;
  int last_xfer_cyc = -10;
  int streak = 0;
  int done_cyc = 0;
  logic [7:0] exp_words[$];
  int exp_out[$];          // 1 = done expected, 2 = err expected
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a legal burst of len words carries seed+i mod 256.
  task automatic model_push(input int len, input int seed);
    if (len == 0) begin
      exp_out.push_back(1);
    end else if (len > DEPTH - 1) begin
      exp_out.push_back(2);
    end else begin
      for (int i = 0; i < len; i++) exp_words.push_back(8'((seed + i) % 256));
      exp_out.push_back(1);
    end
  endtask

  task automatic issue(input int len, input int seed);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      check("cmd_ready_timeout", 0, 1);
    end else begin
      model_push(len, seed);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = LEN_W'(len);
      bus.cmd_seed  = 8'(seed);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_out.size() != 0 || bus.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", int'(n < 500), 1);
  endtask

  task automatic wait_words(input int target);
    int n;
    n = 0;
    while (words_seen < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) check("word_wait_timeout", words_seen, target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int d0;
    int e0;
    int n;
    bus.cmd_valid  = 1'b0;
    bus.cmd_len    = '0;
    bus.cmd_seed   = '0;
    bus.fifo_count = '0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (ap_rst) begin
            prev_stall = 1'b0;
          end else begin
            if (bus.cmd_ready) check("ready_only_idle", bus.busy, 0);
            if (prev_stall) begin
              check("hold_valid", bus.out_V_V_TVALID, 1);
              check("hold_data", bus.out_V_V_TDATA, prev_data);
            end
            if (bus.out_V_V_TVALID && bus.out_V_V_TREADY) begin
              if (exp_words.size() == 0) check("unexpected_word", 1, 0);
              else check("word", bus.out_V_V_TDATA, exp_words.pop_front());
              words_seen++;
              streak = (cyc == last_xfer_cyc + 1) ? streak + 1 : 1;
              last_xfer_cyc = cyc;
            end
            prev_stall = bus.out_V_V_TVALID && !bus.out_V_V_TREADY;
            prev_data  = bus.out_V_V_TDATA;
            if (bus.done || bus.err) begin
              check("done_err_exclusive", int'(bus.done && bus.err), 0);
              if (exp_out.size() == 0) check("unexpected_end", 1, 0);
              else check("end_kind", bus.done ? 1 : 2, exp_out.pop_front());
              check("words_left_at_end", exp_words.size(), 0);
              if (bus.done) done_seen++;
              if (bus.err) err_seen++;
              done_cyc = cyc;
            end
          end
        end
      end
      begin : stim
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", bus.out_V_V_TVALID, 0);
        check("rst_tdata", bus.out_V_V_TDATA, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        @(posedge clk);
        #1 ap_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", bus.cmd_ready, 1);

        // V1: wraparound data, back-to-back transfers, done right after last
        issue(4, 'hFE);
        wait_idle();
        check("v1_streak", streak, 4);
        check("v1_done_timing", done_cyc, last_xfer_cyc + 1);

        // V2: stall after word 0
        base = words_seen;
        d0 = done_seen;
        issue(3, 'h05);
        wait_words(base + 1);
        #1 dir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 dir_ready = 1'b1;
        wait_idle();
        check("v2_words", words_seen - base, 3);
        check("v2_dones", done_seen - d0, 1);

        // V3: wait for space (clamped count, then 14, then 11)
        bus.fifo_count = 14'd20;
        issue(4, 'h30);
        repeat (4) begin
          @(negedge clk);
          check("v3_clamp_wait", bus.out_V_V_TVALID, 0);
        end
        @(posedge clk);
        #1 bus.fifo_count = 14'd14;
        repeat (4) begin
          @(negedge clk);
          check("v3_wait", bus.out_V_V_TVALID, 0);
        end
        @(posedge clk);
        #1 bus.fifo_count = 14'd11;
        n = 0;
        @(negedge clk);
        while (!bus.out_V_V_TVALID && n < 5) begin
          @(negedge clk);
          n++;
        end
        check("v3_start_latency_ok", int'(n <= 2), 1);
        wait_idle();
        bus.fifo_count = 14'd0;

        // V4: len 0 -> done, len 16 -> err, len 15 (largest legal) -> done
        d0 = done_seen;
        e0 = err_seen;
        issue(0, 'h01);
        wait_idle();
        issue(16, 'h02);
        wait_idle();
        issue(15, 'hF8);
        wait_idle();
        check("v4_dones", done_seen - d0, 2);
        check("v4_errs", err_seen - e0, 1);

        // V5: reset after word 2 of an 8-word burst
        base = words_seen;
        d0 = done_seen;
        issue(8, 'h80);
        wait_words(base + 3);
        #1 ap_rst = 1'b1;
        exp_words.delete();
        exp_out.delete();
        @(posedge clk);
        @(negedge clk);
        check("v5_tvalid_low", bus.out_V_V_TVALID, 0);
        check("v5_no_done", bus.done, 0);
        check("v5_busy_low", bus.busy, 0);
        check("v5_ready_in_rst", bus.cmd_ready, 0);
        @(posedge clk);
        #1 ap_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("v5_ready_after", bus.cmd_ready, 1);
        check("v5_done_count", done_seen - d0, 0);
        issue(3, 'h10);
        wait_idle();
        check("v5_new_cmd_done", done_seen - d0, 1);

        // V6: back-to-back commands
        base = words_seen;
        d0 = done_seen;
        issue(2, 'hA0);
        issue(2, 'hB0);
        wait_idle();
        check("v6_words", words_seen - base, 4);
        check("v6_dones", done_seen - d0, 2);

        // Randomized commands with random backpressure
        rand_mode = 1'b1;
        for (int k = 0; k < 25; k++) begin
          issue(int'($urandom_range(0, 17)), int'($urandom_range(0, 255)));
        end
        wait_idle();
        rand_mode = 1'b0;
        check("final_words_empty", exp_words.size(), 0);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
